// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA overlay pixel path.
package vga_pkg;

  localparam logic [1:0] WP_BKGD          = 2'd0;
  localparam logic [1:0] WP_PATH          = 2'd1;
  localparam logic [1:0] WP_OBST          = 2'd2;
  localparam logic [1:0] ICON_TRANSPARENT = 2'd0;

  localparam int PIPE_LAT = 3;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] orient;
  } loc_t;

  typedef enum logic [1:0] {
    LOC_IDLE    = 2'd0,
    LOC_PENDING = 2'd1,
    LOC_APPLY   = 2'd2
  } loc_state_t;

endpackage

// File: rtl/loc_shadow_fsm.sv
// Double-buffered robot location: offers are held pending and copied to the
// shadow copy used for drawing only at the start of vertical blank.
module loc_shadow_fsm
  import vga_pkg::*;
#(
  parameter int INIT_X = 64,
  parameter int INIT_Y = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vblank_start,
  input  logic loc_valid,
  input  loc_t loc_in,
  output loc_t shadow,
  output logic loc_ack
);

  loc_state_t state, state_nxt;
  loc_t       pending;
  logic       apply_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOC_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOC_IDLE:    if (loc_valid) state_nxt = LOC_PENDING;
      LOC_PENDING: if (vblank_start) state_nxt = LOC_APPLY;
      LOC_APPLY:   state_nxt = loc_valid ? LOC_PENDING : LOC_IDLE;
      default:     state_nxt = LOC_IDLE;
    endcase
  end

  always_comb begin
    apply_now = (state == LOC_APPLY);
    loc_ack   = apply_now;
  end

  // Latest offer wins; pending is only read in APPLY, after it has been written.
  always_ff @(posedge clk) begin
    if (loc_valid) pending <= loc_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         shadow <= {8'(INIT_X), 8'(INIT_Y), 3'd0};
    else if (apply_now) shadow <= pending;
  end

endmodule

// File: rtl/pixel_fetch_sched.sv
// Per-pixel world/icon ROM address generation with video timing realigned to
// the returned ROM data (fixed 3-cycle latency).
module pixel_fetch_sched
  import vga_pkg::*;
#(
  parameter int MAP_LOG2   = 7,
  parameter int SCALE_LOG2 = 2,
  parameter int ICON_LOG2  = 4,
  parameter int VIS_ROWS   = 480,
  parameter int INIT_X     = 64,
  parameter int INIT_Y     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  pixel_row,
  input  logic [9:0]  pixel_column,
  input  logic        video_on_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        loc_valid,
  input  logic [7:0]  loc_x,
  input  logic [7:0]  loc_y,
  input  logic [2:0]  loc_orient,
  output logic        loc_ack,
  output logic [13:0] world_addr,
  input  logic [1:0]  world_data,
  output logic [10:0] icon_addr,
  input  logic [1:0]  icon_data,
  output logic [1:0]  world_pixel,
  output logic [1:0]  icon,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync
);

  localparam logic signed [10:0] ICON_OFS = 11'(1 << (ICON_LOG2 - 1));
  localparam logic signed [10:0] ICON_MAX = 11'((1 << ICON_LOG2) - 1);

  loc_t loc_in, shadow;
  logic vblank_start;

  assign loc_in       = {loc_x, loc_y, loc_orient};
  assign vblank_start = (pixel_row == 10'(VIS_ROWS)) && (pixel_column == 10'd0);

  loc_shadow_fsm #(
    .INIT_X (INIT_X),
    .INIT_Y (INIT_Y)
  ) u_loc (
    .clk          (clk),
    .rst_n        (rst_n),
    .vblank_start (vblank_start),
    .loc_valid    (loc_valid),
    .loc_in       (loc_in),
    .shadow       (shadow),
    .loc_ack      (loc_ack)
  );

  logic [9:0]        row_cell, col_cell;
  logic              oob_c, hit_c;
  logic signed [10:0] cx, cy, dx, dy;

  always_comb begin
    row_cell = pixel_row >> SCALE_LOG2;
    col_cell = pixel_column >> SCALE_LOG2;
    oob_c    = ((row_cell >> MAP_LOG2) != '0) || ((col_cell >> MAP_LOG2) != '0);
    cx       = signed'({3'b000, shadow.x} << SCALE_LOG2);
    cy       = signed'({3'b000, shadow.y} << SCALE_LOG2);
    // 11-bit wrap cannot alias into the window: col - cx + 8 stays below 1032.
    dx       = signed'({1'b0, pixel_column}) - cx + ICON_OFS;
    dy       = signed'({1'b0, pixel_row}) - cy + ICON_OFS;
    hit_c    = (dx >= 0) && (dx <= ICON_MAX) && (dy >= 0) && (dy <= ICON_MAX);
  end

  logic hit_p1, oob_p1, vid_p1, hs_p1, vs_p1, vld_p1;
  logic hit_p2, oob_p2, vid_p2, hs_p2, vs_p2, vld_p2;

  // S1: ROM addresses and per-pixel flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      world_addr <= '0;
      icon_addr  <= '0;
      hit_p1     <= 1'b0;
      oob_p1     <= 1'b0;
      vid_p1     <= 1'b0;
      hs_p1      <= 1'b1;
      vs_p1      <= 1'b1;
      vld_p1     <= 1'b0;
    end else begin
      world_addr <= {row_cell[MAP_LOG2-1:0], col_cell[MAP_LOG2-1:0]};
      icon_addr  <= {shadow.orient, dy[ICON_LOG2-1:0], dx[ICON_LOG2-1:0]};
      hit_p1     <= hit_c;
      oob_p1     <= oob_c;
      vid_p1     <= video_on_in;
      hs_p1      <= hsync_in;
      vs_p1      <= vsync_in;
      vld_p1     <= 1'b1;
    end
  end

  // S2: ROM data returns; flags wait one more stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_p2 <= 1'b0;
      oob_p2 <= 1'b0;
      vid_p2 <= 1'b0;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
      vld_p2 <= 1'b0;
    end else begin
      hit_p2 <= hit_p1;
      oob_p2 <= oob_p1;
      vid_p2 <= vid_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      vld_p2 <= vld_p1;
    end
  end

  // S3: aligned outputs, blanked until the pipeline has refilled after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      world_pixel <= '0;
      icon        <= '0;
      video_on    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
    end else begin
      world_pixel <= (vld_p2 && !oob_p2) ? world_data : WP_BKGD;
      icon        <= (vld_p2 && hit_p2) ? icon_data : ICON_TRANSPARENT;
      video_on    <= vld_p2 && vid_p2;
      hsync       <= vld_p2 ? hs_p2 : 1'b1;
      vsync       <= vld_p2 ? vs_p2 : 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_fetch_sched.sv
// Directed bench for pixel_fetch_sched with small behavioural ROM models.
module tb_pixel_fetch_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pixel_row, pixel_column;
  logic        video_on_in, hsync_in, vsync_in;
  logic        loc_valid;
  logic [7:0]  loc_x, loc_y;
  logic [2:0]  loc_orient;
  logic        loc_ack;
  logic [13:0] world_addr;
  logic [1:0]  world_data;
  logic [10:0] icon_addr;
  logic [1:0]  icon_data;
  logic [1:0]  world_pixel, icon;
  logic        video_on, hsync, vsync;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pixel_fetch_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pixel_row    (pixel_row),
    .pixel_column (pixel_column),
    .video_on_in  (video_on_in),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .loc_valid    (loc_valid),
    .loc_x        (loc_x),
    .loc_y        (loc_y),
    .loc_orient   (loc_orient),
    .loc_ack      (loc_ack),
    .world_addr   (world_addr),
    .world_data   (world_data),
    .icon_addr    (icon_addr),
    .icon_data    (icon_data),
    .world_pixel  (world_pixel),
    .icon         (icon),
    .video_on     (video_on),
    .hsync        (hsync),
    .vsync        (vsync)
  );

  // Synchronous ROMs, one cycle of latency; icon data is never transparent.
  always @(posedge clk) begin
    world_data <= world_addr[1:0] ^ world_addr[8:7];
    icon_data  <= {1'b1, icon_addr[0]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pix(input int r, input int c);
    pixel_row    = 10'(r);
    pixel_column = 10'(c);
    step(3);
  endtask

  task automatic send_loc(input int x, input int y, input int o);
    loc_valid  = 1'b1;
    loc_x      = 8'(x);
    loc_y      = 8'(y);
    loc_orient = 3'(o);
    step(1);
    loc_valid  = 1'b0;
  endtask

  task automatic vblank(input string tag);
    pixel_row    = 10'd480;
    pixel_column = 10'd0;
    step(1);
    chk({tag, "_ack"}, 32'(loc_ack), 32'd1);
    pixel_row = 10'd0;
    step(1);
    chk({tag, "_ack_drop"}, 32'(loc_ack), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pixel_row = '0; pixel_column = '0;
    video_on_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    loc_valid = 1'b0; loc_x = '0; loc_y = '0; loc_orient = '0;
    step(2);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_video_on", 32'(video_on), 32'd0);
    chk("rst_world_pixel", 32'(world_pixel), 32'd0);
    chk("rst_icon", 32'(icon), 32'd0);
    chk("rst_loc_ack", 32'(loc_ack), 32'd0);
    chk("rst_world_addr", 32'(world_addr), 32'd0);

    rst_n = 1'b1;
    step(1); chk("vid_lat1", 32'(video_on), 32'd0);
    step(1); chk("vid_lat2", 32'(video_on), 32'd0);
    step(1); chk("vid_lat3", 32'(video_on), 32'd1);
    chk("hsync_lat3", 32'(hsync), 32'd0);

    // Reset shadow (64,64,0): window origin at col/row 248
    pix(248, 248);
    chk("init_icon_addr", 32'(icon_addr), 32'd0);
    chk("init_icon", 32'(icon), 32'd2);

    // Row 8 sweep: map_row 2, map_col = col/4; ROM gives (col/4)^2
    pixel_row = 10'd8;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) pixel_column = 10'(i);
      step(1);
      if (i < 16) chk("sweep_addr", 32'(world_addr), 32'(256 + i / 4));
      if (i >= 2) chk("sweep_pixel", 32'(world_pixel), 32'(((i - 2) / 4) ^ 2));
    end

    // Map boundary
    pix(508, 4);
    chk("edge_addr", 32'(world_addr), 32'd16257);
    chk("edge_pixel", 32'(world_pixel), 32'd2);
    pix(512, 4);
    chk("oob_row_addr", 32'(world_addr), 32'd1);
    chk("oob_row_pixel", 32'(world_pixel), 32'd0);
    pix(8, 512);
    chk("oob_col_pixel", 32'(world_pixel), 32'd0);

    // Shadow (10,20,3): window cols 32..47, rows 72..87
    send_loc(10, 20, 3);
    vblank("apply_a");
    pix(72, 32);
    chk("icon_tl_addr", 32'(icon_addr), 32'd768);
    chk("icon_tl", 32'(icon), 32'd2);
    pix(87, 47);
    chk("icon_br_addr", 32'(icon_addr), 32'd1023);
    chk("icon_br", 32'(icon), 32'd3);
    pix(72, 48);
    chk("icon_right_miss", 32'(icon), 32'd0);
    pix(71, 32);
    chk("icon_above_miss", 32'(icon), 32'd0);

    // Shadow (0,0,4): window clipped to 0..7 on both axes
    send_loc(0, 0, 4);
    vblank("apply_clip");
    pix(0, 0);
    chk("clip_origin_addr", 32'(icon_addr), 32'd1160);
    chk("clip_origin", 32'(icon), 32'd2);
    pix(7, 7);
    chk("clip_br_addr", 32'(icon_addr), 32'd1279);
    chk("clip_br", 32'(icon), 32'd3);
    pix(0, 8);
    chk("clip_miss", 32'(icon), 32'd0);
    pix(0, 1023);
    chk("wrap_col_miss", 32'(icon), 32'd0);
    pix(1023, 0);
    chk("wrap_row_miss", 32'(icon), 32'd0);

    // Two offers in one frame: only the latest is applied, with one ack
    send_loc(5, 5, 2);
    step(5);
    chk("pend_no_ack1", 32'(loc_ack), 32'd0);
    send_loc(9, 9, 5);
    step(2);
    chk("pend_no_ack2", 32'(loc_ack), 32'd0);
    vblank("latest");
    step(3);
    chk("single_ack", 32'(loc_ack), 32'd0);
    pix(28, 28);
    chk("latest_addr", 32'(icon_addr), 32'd1280);
    chk("latest_hit", 32'(icon), 32'd2);
    pix(12, 12);
    chk("stale_miss", 32'(icon), 32'd0);

    // Offer during APPLY: first value acked now, second at the next vblank
    send_loc(3, 3, 1);
    pixel_row = 10'd480; pixel_column = 10'd0;
    step(1);
    chk("coin_ack1", 32'(loc_ack), 32'd1);
    loc_valid = 1'b1; loc_x = 8'd7; loc_y = 8'd7; loc_orient = 3'd6;
    pixel_row = 10'd0;
    step(1);
    loc_valid = 1'b0;
    chk("coin_ack1_drop", 32'(loc_ack), 32'd0);
    pix(4, 4);
    chk("coin_first_addr", 32'(icon_addr), 32'd256);
    chk("coin_first_hit", 32'(icon), 32'd2);
    vblank("coin_second");
    pix(20, 20);
    chk("coin_second_addr", 32'(icon_addr), 32'd1536);

    // Offer coincident with vblank while idle waits for the next frame
    pixel_row = 10'd480; pixel_column = 10'd0;
    loc_valid = 1'b1; loc_x = 8'd1; loc_y = 8'd2; loc_orient = 3'd7;
    step(1);
    loc_valid = 1'b0;
    pixel_row = 10'd0;
    chk("idle_vb_no_ack", 32'(loc_ack), 32'd0);
    step(2);
    chk("idle_vb_no_apply", 32'(loc_ack), 32'd0);
    pix(20, 20);
    chk("idle_vb_shadow_kept", 32'(icon_addr), 32'd1536);
    vblank("idle_vb_next");
    pix(0, 0);
    chk("idle_vb_applied", 32'(icon_addr), 32'd1796);

    // Mid-line reset clears outputs at once and restores the default shadow
    video_on_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    pix(0, 4);
    chk("pre_rst_world", 32'(world_pixel), 32'd1);
    chk("pre_rst_icon", 32'(icon), 32'd2);
    chk("pre_rst_hsync", 32'(hsync), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_video_on", 32'(video_on), 32'd0);
    chk("mid_rst_hsync", 32'(hsync), 32'd1);
    chk("mid_rst_vsync", 32'(vsync), 32'd1);
    chk("mid_rst_world", 32'(world_pixel), 32'd0);
    chk("mid_rst_icon", 32'(icon), 32'd0);
    chk("mid_rst_icon_addr", 32'(icon_addr), 32'd0);
    step(2);
    rst_n = 1'b1;
    pix(248, 248);
    chk("post_rst_shadow_addr", 32'(icon_addr), 32'd0);
    chk("post_rst_shadow_hit", 32'(icon), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
